// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Shares one sequential multiplier between two requesters. A round-robin
//   arbiter accepts one request in IDLE and latches its operands. The block
//   holds them on the multiplier inputs until the multiplier fetches them,
//   then captures the product. The product and the owner id are returned
//   over a valid/ready response port. Only one job is in flight at a time.
// Ports
//   mac_clk_i / mac_nreset_i          clock, async active-low reset
//   req_valid_i / req_ready_o [1:0]   per-requester handshake (ready only in IDLE)
//   req{0,1}_{a,b}_i                  operands per requester
//   rsp_valid_o/rsp_id_o/rsp_data_o   response, held until rsp_ready_i
//   abort_i                           synchronous abort, highest priority
//   busy_o                            FSM not in IDLE
//   mul_*                             multiplier operand/reset/handshake lines
module mul_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic               mac_clk_i,
  input  logic               mac_nreset_i,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [WIDTH-1:0]   req0_a_i,
  input  logic [WIDTH-1:0]   req0_b_i,
  input  logic [WIDTH-1:0]   req1_a_i,
  input  logic [WIDTH-1:0]   req1_b_i,
  output logic               rsp_valid_o,
  output logic               rsp_id_o,
  output logic [2*WIDTH-1:0] rsp_data_o,
  input  logic               rsp_ready_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic [WIDTH-1:0]   mul_multiplicand_o,
  output logic [WIDTH-1:0]   mul_multiplier_o,
  output logic               mul_nreset_o,
  input  logic               mul_fetching_i,
  input  logic               mul_is_result_i,
  input  logic [2*WIDTH-1:0] mul_result_i
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_id;
  logic               r_last_grant;
  logic [2*WIDTH-1:0] r_data;
  logic               r_mul_nreset;
  logic [1:0]         w_grant;
  logic               w_accept;

  // Round robin: a lone requester always wins; on a tie the one that was
  // not served last wins. r_last_grant resets to 1 so requester 0 goes first.
  assign w_grant[0] = req_valid_i[0] & (~req_valid_i[1] | r_last_grant);
  assign w_grant[1] = req_valid_i[1] & (~req_valid_i[0] | ~r_last_grant);

  // State register
  always_ff @(posedge mac_clk_i or negedge mac_nreset_i) begin
    if (!mac_nreset_i) r_state <= IDLE;
    else               r_state <= w_next;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (|w_grant)        w_next = LOAD;
      LOAD: if (mul_fetching_i)  w_next = WAIT;
      WAIT: if (mul_is_result_i) w_next = RESP;
      RESP: if (rsp_ready_i)     w_next = IDLE;
      default:                   w_next = IDLE;
    endcase
    if (abort_i) w_next = IDLE;
  end

  // Outputs. Ready is suppressed during reset and on an abort cycle so a
  // requester never sees an accept that the FSM then drops.
  always_comb begin
    w_accept    = (r_state == IDLE) && !abort_i && mac_nreset_i && (|w_grant);
    req_ready_o = w_accept ? w_grant : 2'b00;
    rsp_valid_o = (r_state == RESP);
    busy_o      = (r_state != IDLE);
  end

  // Datapath: operand latch, product capture, arbitration history.
  // In LOAD a result pulse belongs to a previous job, so capture is WAIT-only.
  always_ff @(posedge mac_clk_i or negedge mac_nreset_i) begin
    if (!mac_nreset_i) begin
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_data       <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= w_grant[1] ? req1_a_i : req0_a_i;
        r_b  <= w_grant[1] ? req1_b_i : req0_b_i;
        r_id <= w_grant[1];
      end
      if (!abort_i && r_state == WAIT && mul_is_result_i)
        r_data <= mul_result_i;
      if (!abort_i && r_state == RESP && rsp_ready_i)
        r_last_grant <= r_id;
    end
  end

  // Multiplier reset: low in reset, then low for exactly one cycle after
  // any abort so an in-flight multiplication is discarded cleanly.
  always_ff @(posedge mac_clk_i or negedge mac_nreset_i) begin
    if (!mac_nreset_i) r_mul_nreset <= 1'b0;
    else               r_mul_nreset <= ~abort_i;
  end

  assign mul_nreset_o       = r_mul_nreset;
  assign mul_multiplicand_o = r_a;
  assign mul_multiplier_o   = r_b;
  assign rsp_id_o           = r_id;
  assign rsp_data_o         = r_data;

endmodule
